// File: rtl/flag_branch_unit_if.sv
// Signal bundle between the pipeline (master) and the flag/branch unit (slave).
// The bundle covers the EX flag source, the ID branch operands and the redirect outputs.
interface flag_branch_unit_if;
    logic [2:0]  alu_flags;
    logic [3:0]  ex_op;
    logic        ex_valid;
    logic        stall;
    logic        id_valid;
    logic        id_is_b;
    logic        id_is_br;
    logic [2:0]  id_cond;
    logic [8:0]  id_imm9;
    logic [15:0] id_pc_plus2;
    logic [15:0] id_rs_data;
    logic [2:0]  flags_q;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        flush;
    logic        in_shadow;

    modport master (
        output alu_flags, ex_op, ex_valid, stall, id_valid, id_is_b, id_is_br,
               id_cond, id_imm9, id_pc_plus2, id_rs_data,
        input  flags_q, branch_taken, branch_target, flush, in_shadow
    );

    modport slave (
        input  alu_flags, ex_op, ex_valid, stall, id_valid, id_is_b, id_is_br,
               id_cond, id_imm9, id_pc_plus2, id_rs_data,
        output flags_q, branch_taken, branch_target, flush, in_shadow
    );
endinterface

// File: rtl/flag_branch_unit.sv
// The unit holds the architectural flags {N,Z,V} and resolves conditional branches in ID.
// It uses the flags bypassed from EX and squashes the single wrong-path slot after a taken branch.
module flag_branch_unit (
    input  logic               clk,
    input  logic               rst,
    flag_branch_unit_if.slave  bus
);
    typedef enum logic {IDLE, SHADOW} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_flags, w_eff;
    logic        w_wr, w_wr_z, w_wr_nv;
    logic        w_n, w_z, w_v, w_cond_true;
    logic        w_taken;
    logic [15:0] w_b_tgt, w_target;

    // Effective flags are the value flags_q will take at the next edge.
    always_comb begin
        w_wr    = bus.ex_valid & ~bus.stall;
        w_wr_nv = w_wr & (bus.ex_op == 4'b0000 || bus.ex_op == 4'b0001);
        w_wr_z  = w_wr & (bus.ex_op == 4'b0000 || bus.ex_op == 4'b0001 ||
                          bus.ex_op == 4'b0010 || bus.ex_op == 4'b0100 ||
                          bus.ex_op == 4'b0101 || bus.ex_op == 4'b0110);
        w_eff   = r_flags;
        if (w_wr_nv) begin
            w_eff[2] = bus.alu_flags[2];
            w_eff[0] = bus.alu_flags[0];
        end
        if (w_wr_z)
            w_eff[1] = bus.alu_flags[1];
    end

    assign w_n = w_eff[2];
    assign w_z = w_eff[1];
    assign w_v = w_eff[0];

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.id_cond)
            3'b000:  w_cond_true = ~w_z;
            3'b001:  w_cond_true = w_z;
            3'b010:  w_cond_true = ~w_z & ~w_n;
            3'b011:  w_cond_true = w_n;
            3'b100:  w_cond_true = w_z | ~w_n;
            3'b101:  w_cond_true = w_z | w_n;
            3'b110:  w_cond_true = w_v;
            default: w_cond_true = 1'b1;
        endcase
    end

    // The word offset is scaled to bytes; the sum wraps modulo 2^16.
    assign w_b_tgt = bus.id_pc_plus2 + {{6{bus.id_imm9[8]}}, bus.id_imm9, 1'b0};

    always_comb begin
        w_state_nxt = r_state;
        w_taken     = 1'b0;
        w_target    = 16'h0000;
        case (r_state)
            IDLE: begin
                if (~rst & bus.id_valid & ~bus.stall &
                    (bus.id_is_b | bus.id_is_br) & w_cond_true) begin
                    w_taken     = 1'b1;
                    w_target    = bus.id_is_br ? bus.id_rs_data : w_b_tgt;
                    w_state_nxt = SHADOW;
                end
            end
            SHADOW: begin
                if (~bus.stall)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A stall leaves w_eff equal to r_flags and w_state_nxt equal to r_state, so the register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_flags <= w_eff;
        end
    end

    assign bus.flags_q       = r_flags;
    assign bus.branch_taken  = w_taken;
    assign bus.flush         = w_taken;
    assign bus.branch_target = w_target;
    assign bus.in_shadow     = (r_state == SHADOW);
endmodule

// File: tb/tb_flag_branch_unit.sv
// This bench compares flag_branch_unit against a behavioural model on every cycle.
// It also applies directed vectors whose expected values were worked out by hand.
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_branch_unit_if bus ();
    flag_branch_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural flags and of the shadow flag.
    bit [2:0] m_flags = 3'b000, m_nx_flags;
    bit       m_sh = 1'b0, m_nx_sh;
    bit       m_known = 1'b0;

    function automatic bit [2:0] model_eff(input bit [2:0] cur);
        bit [15:0] zmask = 16'h0077;
        bit [15:0] nvmask = 16'h0003;
        bit [2:0]  e = cur;
        bit        wr = bus.ex_valid && !bus.stall;
        if (wr && zmask[bus.ex_op]) e[1] = bus.alu_flags[1];
        if (wr && nvmask[bus.ex_op]) begin
            e[2] = bus.alu_flags[2];
            e[0] = bus.alu_flags[0];
        end
        return e;
    endfunction

    function automatic bit model_cond(input bit [2:0] c, input bit [2:0] e);
        bit n = e[2], z = e[1], v = e[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        bit [2:0] e;
        bit       tk;
        int       off;
        int       tgt;
        e  = model_eff(m_flags);
        tk = !rst && !m_sh && bus.id_valid && !bus.stall &&
             (bus.id_is_b || bus.id_is_br) && model_cond(bus.id_cond, e);
        off = bus.id_imm9[8] ? int'(bus.id_imm9) - 512 : int'(bus.id_imm9);
        tgt = !tk ? 0 : bus.id_is_br ? int'(bus.id_rs_data)
                                     : ((int'(bus.id_pc_plus2) + off * 2) & 32'hFFFF);
        if (m_known) begin
            chk("mdl_flags_q", 32'(bus.flags_q), 32'(m_flags));
            chk("mdl_taken", 32'(bus.branch_taken), 32'(tk));
            chk("mdl_flush", 32'(bus.flush), 32'(tk));
            chk("mdl_target", 32'(bus.branch_target), 32'(tgt));
            chk("mdl_in_shadow", 32'(bus.in_shadow), 32'(m_sh));
        end
        if (rst) begin
            m_nx_flags = 3'b000;
            m_nx_sh    = 1'b0;
        end else if (bus.stall) begin
            m_nx_flags = m_flags;
            m_nx_sh    = m_sh;
        end else begin
            m_nx_flags = e;
            m_nx_sh    = m_sh ? 1'b0 : tk;
        end
    end

    always @(posedge clk) begin
        if (rst) m_known = 1'b1;
        m_flags = m_nx_flags;
        m_sh    = m_nx_sh;
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask
    task automatic obs();
        @(negedge clk); #1;
    endtask
    task automatic clr();
        bus.alu_flags = 3'b000; bus.ex_op = 4'b1111; bus.ex_valid = 1'b0; bus.stall = 1'b0;
        bus.id_valid = 1'b0; bus.id_is_b = 1'b0; bus.id_is_br = 1'b0; bus.id_cond = 3'b000;
        bus.id_imm9 = 9'h000; bus.id_pc_plus2 = 16'h0000; bus.id_rs_data = 16'h0000;
    endtask
    task automatic ex(input bit [3:0] op, input bit [2:0] fl);
        bus.ex_valid = 1'b1; bus.ex_op = op; bus.alu_flags = fl;
    endtask
    task automatic br(input bit is_br, input bit [2:0] c, input bit [8:0] imm,
                      input bit [15:0] pc, input bit [15:0] rs);
        bus.id_valid = 1'b1; bus.id_is_b = !is_br; bus.id_is_br = is_br; bus.id_cond = c;
        bus.id_imm9 = imm; bus.id_pc_plus2 = pc; bus.id_rs_data = rs;
    endtask

    logic [7:0] cond_tab [8] = '{8'h33, 8'hCC, 8'h03, 8'hF0, 8'hCF, 8'hFC, 8'hAA, 8'hFF};

    initial begin
        clr();
        rst = 1'b1;
        br(1'b0, 3'd7, 9'h004, 16'h0100, 16'h0000);
        obs();
        chk("rst_flags", 32'(bus.flags_q), 32'h0);
        chk("rst_shadow", 32'(bus.in_shadow), 32'h0);
        chk("rst_taken", 32'(bus.branch_taken), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_target", 32'(bus.branch_target), 32'h0);
        nxt(); obs();

        // EX flag bypass feeding a same-cycle B.EQ
        nxt(); rst = 1'b0; clr();
        ex(4'b0001, 3'b010); br(1'b0, 3'd1, 9'h004, 16'h0010, 16'h0000);
        obs();
        chk("byp_taken", 32'(bus.branch_taken), 32'h1);
        chk("byp_target", 32'(bus.branch_target), 32'h0018);
        nxt(); clr(); obs();
        chk("byp_flags", 32'(bus.flags_q), 32'h2);
        chk("byp_shadow", 32'(bus.in_shadow), 32'h1);
        nxt(); obs();

        // Partial flag writes
        nxt(); ex(4'b0010, 3'b000); obs();
        nxt(); clr(); ex(4'b1010, 3'b000); obs();
        chk("zonly_flags", 32'(bus.flags_q), 32'h0);
        nxt(); ex(4'b1010, 3'b111); obs();
        chk("nowrite_flags", 32'(bus.flags_q), 32'h0);
        nxt(); clr(); bus.alu_flags = 3'b111; bus.ex_op = 4'b0000; obs();
        chk("noop_flags", 32'(bus.flags_q), 32'h0);
        nxt(); clr(); obs();
        chk("exinv_flags", 32'(bus.flags_q), 32'h0);

        // Target arithmetic
        nxt(); br(1'b0, 3'd7, 9'h1FF, 16'h0000, 16'h5555); obs();
        chk("b_wrap", 32'(bus.branch_target), 32'hFFFE);
        nxt(); clr(); obs();
        nxt(); br(1'b1, 3'd7, 9'h0AA, 16'h4444, 16'h1234); obs();
        chk("br_target", 32'(bus.branch_target), 32'h1234);
        nxt(); clr(); obs();

        // Stall held in SHADOW, then a back-to-back branch
        nxt(); br(1'b0, 3'd7, 9'h010, 16'h0200, 16'h0000); obs();
        chk("sh_first_taken", 32'(bus.branch_taken), 32'h1);
        for (int i = 0; i < 3; i++) begin
            nxt(); bus.stall = 1'b1; obs();
            chk("sh_stall_shadow", 32'(bus.in_shadow), 32'h1);
            chk("sh_stall_taken", 32'(bus.branch_taken), 32'h0);
        end
        nxt(); bus.stall = 1'b0; obs();
        chk("sh_release_shadow", 32'(bus.in_shadow), 32'h1);
        chk("sh_release_taken", 32'(bus.branch_taken), 32'h0);
        nxt(); obs();
        chk("b2b_shadow", 32'(bus.in_shadow), 32'h0);
        chk("b2b_taken", 32'(bus.branch_taken), 32'h1);
        chk("b2b_target", 32'(bus.branch_target), 32'h0220);
        nxt(); clr(); obs();

        // Stall in IDLE defers both the flag write and the branch
        nxt(); bus.stall = 1'b1; ex(4'b0000, 3'b110); br(1'b0, 3'd1, 9'h000, 16'h0300, 16'h0); obs();
        chk("idle_stall_taken", 32'(bus.branch_taken), 32'h0);
        nxt(); obs();
        chk("idle_stall_flags", 32'(bus.flags_q), 32'h0);
        chk("idle_stall_shadow", 32'(bus.in_shadow), 32'h0);
        nxt(); bus.stall = 1'b0; obs();
        chk("idle_rel_taken", 32'(bus.branch_taken), 32'h1);
        nxt(); clr(); obs();
        chk("idle_rel_flags", 32'(bus.flags_q), 32'h6);

        // Every condition against every effective flag value
        for (int e = 0; e < 8; e++) begin
            for (int c = 0; c < 8; c++) begin
                nxt(); clr();
                ex(4'b0000, 3'(e)); br(1'b0, 3'(c), 9'h002, 16'h0040, 16'h0); obs();
                chk($sformatf("cond%0d_eff%0d", c, e), 32'(bus.branch_taken),
                    32'(cond_tab[c][e]));
                if (bus.branch_taken) begin
                    nxt(); clr(); obs();
                end
            end
        end

        // Reset mid-SHADOW wins over stall and flag writes
        nxt(); clr(); ex(4'b0000, 3'b111); br(1'b0, 3'd7, 9'h000, 16'h0080, 16'h0); obs();
        nxt(); clr(); rst = 1'b1; bus.stall = 1'b1; ex(4'b0000, 3'b010); obs();
        chk("rsh_pre_flags", 32'(bus.flags_q), 32'h7);
        chk("rsh_pre_shadow", 32'(bus.in_shadow), 32'h1);
        nxt(); clr(); rst = 1'b0; br(1'b0, 3'd7, 9'h002, 16'h0100, 16'h0); obs();
        chk("rsh_flags", 32'(bus.flags_q), 32'h0);
        chk("rsh_shadow", 32'(bus.in_shadow), 32'h0);
        chk("rsh_taken", 32'(bus.branch_taken), 32'h1);
        chk("rsh_target", 32'(bus.branch_target), 32'h0104);
        nxt(); clr(); obs();
        nxt(); obs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
